// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO architectural registers.
// Fixed 34-cycle latency: 33 RUN cycles (32 iterations), one FIX cycle, then DONE.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_r;
  logic [DATA_W-1:0] a_r, b_r, acc_hi, acc_lo;

  function automatic logic [DATA_W-1:0] neg_if(input logic c, input logic [DATA_W-1:0] x);
    return c ? -x : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_if_w(input logic c, input logic [2*DATA_W-1:0] x);
    return c ? -x : x;
  endfunction

  logic              accept, idle_like, iter_done, is_signed, neg_res, div_zero;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_sh, div_diff;
  logic              div_ge;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = start && idle_like;
  assign iter_done = (cnt == CNT_W'(DATA_W));
  assign is_signed = ~op_r[0];
  assign neg_res   = is_signed & (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
  assign div_zero  = (b_r == '0);
  assign a_mag     = neg_if(is_signed & a_r[DATA_W-1], a_r);
  assign b_mag     = neg_if(is_signed & b_r[DATA_W-1], b_r);

  // Multiply: acc_hi holds the running upper product, acc_lo the shifting multiplier.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_sh   = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff = div_sh - {1'b0, b_mag};
  assign div_ge   = ~div_diff[DATA_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN:        state_nxt = iter_done ? FIX : RUN;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        op_r   <= op;
        a_r    <= rs_data;
        b_r    <= rt_data;
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= op[1] ? neg_if(~op[0] & rs_data[DATA_W-1], rs_data)
                        : neg_if(~op[0] & rt_data[DATA_W-1], rt_data);
      end else if (idle_like) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      if (state == RUN && !iter_done) begin
        cnt <= cnt + 1'b1;
        if (!op_r[1]) begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
        end else begin
          acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
          acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
        end
      end
      // FIX: apply signs and commit the result to HI/LO.
      if (state == FIX) begin
        if (!op_r[1]) begin
          {hi, lo} <= neg_if_w(neg_res, {acc_hi, acc_lo});
        end else if (div_zero) begin
          hi <= a_r;
          lo <= '1;
        end else begin
          hi <= neg_if(is_signed & a_r[DATA_W-1], acc_hi);
          lo <= neg_if(neg_res, acc_lo);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at launch, popped on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result as {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, sp;
    logic signed [31:0] sa, sb, sq, sr;
    xa = {{32{a[31]}}, a};
    xb = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    case (o)
      MULT:  begin sp = xa * xb; return sp; end
      MULTU: return {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Ends just after the edge that samples start.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges since the sampling edge until done; gives up after 80.
  task automatic wait_done(input int first, output int lat, output bit busy_ok);
    lat = first;
    busy_ok = 1'b1;
    while (lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (done) return;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic run_table(input string name, input logic [1:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
    int lat; bit bok; logic [63:0] e;
    foreach (ops[i]) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(0, lat, bok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (lat !== 34) begin failures++; $display("FAIL %s_latency[%0d] got=%0d exp=34", name, i, lat); end
      checks++; if (!bok) begin failures++; $display("FAIL %s_busy[%0d] got=0 exp=1", name, i); end
      checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL %s_hi[%0d] op=%0d a=%h b=%h got=%h exp=%h", name, i, ops[i], as[i], bs[i], hi, e[63:32]); end
      checks++; if (lo !== e[31:0]) begin failures++; $display("FAIL %s_lo[%0d] op=%0d a=%h b=%h got=%h exp=%h", name, i, ops[i], as[i], bs[i], lo, e[31:0]); end
    end
  endtask

  task automatic test_mult;
    logic [1:0]  o[] = '{MULT, MULTU, MULT, MULTU, MULT, MULT, MULTU, MULT};
    logic [31:0] a[] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, 0, 0};
    logic [31:0] b[] = '{32'h7, 32'h7, 32'h80000000, 32'hFFFFFFFF, 32'h1234, 0, 0, 0};
    for (int i = 5; i < 8; i++) begin a[i] = $urandom; b[i] = $urandom; end
    run_table("mult", o, a, b);
  endtask

  task automatic test_div;
    logic [1:0]  o[] = '{DIV, DIVU, DIV, DIV, DIVU, DIV, DIV, DIVU, DIV};
    logic [31:0] a[] = '{32'hFFFFFFF9, 32'h7, 32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'h7, 0, 0, 0};
    logic [31:0] b[] = '{32'h2, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 0, 0, 0};
    for (int i = 6; i < 9; i++) begin a[i] = $urandom; b[i] = $urandom_range(1, 1000); end
    run_table("div", o, a, b);
  endtask

  task automatic test_ignore_start;
    int lat, extra; bit bok; logic [63:0] e;
    launch(MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    op = DIV; rs_data = 32'd99; rt_data = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if (lat !== 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL ignore_result got=%h_%h exp=%h", hi, lo, e); end
    checks++; if (lo !== 32'd15) begin failures++; $display("FAIL ignore_lo15 got=%h exp=f", lo); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok; logic [63:0] e;
    launch(DIVU, 32'd1000, 32'd33);
    wait_done(0, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_first got=%h_%h exp=%h", hi, lo, e); end
    op = DIV; rs_data = 32'hFFFFFF9C; rt_data = 32'd7; start = 1'b1;
    exp_q.push_back(model(DIV, 32'hFFFFFF9C, 32'd7));
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
    wait_done(0, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, e); end
  endtask

  task automatic test_reset_abort;
    int lat, cnt_done; bit bok; logic [63:0] e;
    launch(MULTU, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo); end
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) cnt_done++; end
    checks++; if (cnt_done !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", cnt_done); end
    launch(DIVU, 32'd100, 32'd7);
    wait_done(0, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if (lat !== 34) begin failures++; $display("FAIL abort_next_latency got=%0d exp=34", lat); end
    checks++; if ({hi, lo} !== e || lo !== 32'd14) begin failures++; $display("FAIL abort_next_result got=%h_%h exp=%h", hi, lo, e); end
  endtask

  task automatic test_mthi_mtlo;
    int lat; bit bok; logic [63:0] e;
    @(negedge clk); wr_hi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk); wr_hi = 1'b0;
    checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi got=%h exp=a5a5a5a5", hi); end
    wr_lo = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk); wr_lo = 1'b0;
    checks++; if (lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL mtlo got=%h exp=5a5a5a5a", lo); end
    launch(MULTU, 32'd2, 32'd3);
    wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk); wr_lo = 1'b0;
    checks++; if (lo !== 32'h5A5A5A5A || hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mtlo_busy got=%h_%h exp=a5a5a5a5_5a5a5a5a", hi, lo); end
    wait_done(1, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL mt_result got=%h_%h exp=%h", hi, lo, e); end
    @(negedge clk);
    op = MULTU; rs_data = 32'd4; rt_data = 32'd4; start = 1'b1; wr_hi = 1'b1; wdata = 32'h11111111;
    exp_q.push_back(model(MULTU, 32'd4, 32'd4));
    @(negedge clk); start = 1'b0; wr_hi = 1'b0;
    checks++; if (busy !== 1'b1 || hi !== e[63:32]) begin failures++; $display("FAIL start_drops_write got busy=%b hi=%h exp busy=1 hi=%h", busy, hi, e[63:32]); end
    wait_done(0, lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL start_drops_write_result got=%h_%h exp=%h", hi, lo, e); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_mthi_mtlo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
